mul_issue_arbiter: RTL and testbench

//  Shares the single pipelined multiply unit between NUM_REQ reservation stations.

---
 rtl/mul_issue_arbiter_if.sv | 58 +++++
 rtl/mul_issue_arbiter.sv | 133 +++++++++++++
 tb/tb_mul_issue_arbiter.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_issue_arbiter_if.sv
// Shared types and handshake bundle for mul_issue_arbiter.
// mul_issue_pkg carries the multiply decode word. The interface groups the
// requester side (reservation stations) and the multiply-unit side.
// Modport "slave" is the arbiter's view. Modport "master" is the
// environment's view: the reservation stations and the multiply unit.

package mul_issue_pkg;
  // Decode bits handed through to the multiply unit untouched.
  typedef struct packed {
    logic is_signed;  // signed multiply
    logic high_word;  // return the upper 32 bits of the product
    logic set_ov;     // update XER[OV/SO]
    logic set_cr0;    // record form, update CR0
  } mul_decode_t;
endpackage

interface mul_issue_arbiter_if #(
  parameter int NUM_REQ     = 4,
  parameter int RS_ID_WIDTH = 5
);
  import mul_issue_pkg::*;

  // Requester side
  logic [0:NUM_REQ-1]                  req_valid;
  logic [0:NUM_REQ-1]                  req_ready;
  logic [0:NUM_REQ-1][0:RS_ID_WIDTH-1] req_rs_id;
  logic [0:NUM_REQ-1][0:4]             req_result_reg_addr;
  logic [0:NUM_REQ-1][0:31]            req_op1;
  logic [0:NUM_REQ-1][0:31]            req_op2;
  logic [0:NUM_REQ-1][0:31]            req_xer;
  mul_decode_t [0:NUM_REQ-1]           req_control;

  // Multiply-unit side
  logic                    mul_valid;
  logic                    mul_ready;
  logic [0:RS_ID_WIDTH-1]  mul_rs_id;
  logic [0:4]              mul_result_reg_addr;
  logic [0:31]             mul_op1;
  logic [0:31]             mul_op2;
  logic [0:31]             mul_xer;
  mul_decode_t             mul_control;
  logic                    mul_done;
  logic [0:3]              inflight_cnt;

  modport slave (
    input  req_valid, req_rs_id, req_result_reg_addr, req_op1, req_op2,
           req_xer, req_control, mul_ready, mul_done,
    output req_ready, mul_valid, mul_rs_id, mul_result_reg_addr, mul_op1,
           mul_op2, mul_xer, mul_control, inflight_cnt
  );

  modport master (
    output req_valid, req_rs_id, req_result_reg_addr, req_op1, req_op2,
           req_xer, req_control, mul_ready, mul_done,
    input  req_ready, mul_valid, mul_rs_id, mul_result_reg_addr, mul_op1,
           mul_op2, mul_xer, mul_control, inflight_cnt
  );
endinterface

// File: rtl/mul_issue_arbiter.sv
// mul_issue_arbiter: shares one pipelined multiply unit between NUM_REQ
// reservation stations.
// A round-robin grant loads the chosen requester's op into a registered
// issue slot. The slot feeds the multiply unit's valid/ready port. An
// in-flight credit counter caps the number of ops between slot load and
// mul_done at MAX_INFLIGHT, so the unit's pipe never stalls back into issue.
// Optional feature: define MUL_ARB_STATS_EN to add the stat_issued,
// stat_credit_stall and stat_slot_stall counter ports.

module mul_issue_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int RS_ID_WIDTH  = 5,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic               clk,
  input  logic               rst,
  mul_issue_arbiter_if.slave bus
`ifdef MUL_ARB_STATS_EN
  ,
  output logic [0:31]        stat_issued,
  output logic [0:31]        stat_credit_stall,
  output logic [0:31]        stat_slot_stall
`endif
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic {S_EMPTY, S_FULL} slot_state_t;

  slot_state_t      state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] grant;
  logic             any_req;
  logic             slot_free;
  logic             credit_ok;
  logic             load;
  logic             retire;
  logic [3:0]       cnt;

  assign any_req   = |bus.req_valid;
  assign slot_free = (state == S_EMPTY) || bus.mul_ready;
  assign credit_ok = (cnt < 4'(MAX_INFLIGHT)) || bus.mul_done;
  assign load      = !rst && slot_free && credit_ok && any_req;
  // A mul_done with nothing in flight is ignored, so the count never wraps below 0.
  assign retire    = bus.mul_done && (cnt != 4'd0);

  assign bus.mul_valid    = (state == S_FULL);
  assign bus.inflight_cnt = cnt;

  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] cand;
    logic             found;
    // NOTE: every variable gets a value before any branch, so no latch can be inferred.
    grant = rr_ptr;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NUM_REQ)) sum = sum - (PTR_W+1)'(NUM_REQ);
      cand = sum[PTR_W-1:0];
      if (!found && bus.req_valid[cand]) begin
        grant = cand;
        found = 1'b1;
      end
    end
  end

  // Accept strobe: one-hot on the granted requester, only in a load cycle.
  always_comb begin
    bus.req_ready = '0;
    if (load) bus.req_ready[grant] = 1'b1;
  end

  // Issue-slot FSM, payload capture and round-robin pointer.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state  <= S_EMPTY;
      rr_ptr <= '0;
      // NOTE: the payload is reset too, so mul_* never shows stale data after reset.
      bus.mul_rs_id           <= '0;
      bus.mul_result_reg_addr <= '0;
      bus.mul_op1             <= '0;
      bus.mul_op2             <= '0;
      bus.mul_xer             <= '0;
      bus.mul_control         <= '0;
    end else begin
      case (state)
        S_EMPTY: if (load) state <= S_FULL;
        S_FULL:  if (bus.mul_ready && !load) state <= S_EMPTY;
        default: state <= S_EMPTY;
      endcase
      if (load) begin
        bus.mul_rs_id           <= bus.req_rs_id[grant];
        bus.mul_result_reg_addr <= bus.req_result_reg_addr[grant];
        bus.mul_op1             <= bus.req_op1[grant];
        bus.mul_op2             <= bus.req_op2[grant];
        bus.mul_xer             <= bus.req_xer[grant];
        bus.mul_control         <= bus.req_control[grant];
        if (int'(grant) == NUM_REQ - 1) rr_ptr <= '0;
        else                            rr_ptr <= grant + 1'b1;
      end
    end
  end

  // In-flight credit counter: +1 per slot load, -1 per retired op.
  always_ff @(posedge clk) begin
    if (rst)                    cnt <= 4'd0;
    else if (load && !retire)   cnt <= cnt + 4'd1;
    else if (!load && retire)   cnt <= cnt - 4'd1;
  end

`ifdef MUL_ARB_STATS_EN
  // Free-running event counters; they wrap at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issued       <= '0;
      stat_credit_stall <= '0;
      stat_slot_stall   <= '0;
    end else begin
      if (load) stat_issued <= stat_issued + 32'd1;
      if (any_req && slot_free && !credit_ok)
        stat_credit_stall <= stat_credit_stall + 32'd1;
      if (bus.mul_valid && !bus.mul_ready)
        stat_slot_stall <= stat_slot_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mul_issue_arbiter.sv
// Self-checking bench for mul_issue_arbiter: directed steps, a reference
// model of grant/slot/credit behaviour and a scoreboard of issued ops.
module tb_mul_issue_arbiter;
  import mul_issue_pkg::*;

  localparam int NREQ = 4;
  localparam int IDW  = 5;
  localparam int MAXF = 4;

  typedef struct {
    logic [0:IDW-1] rs_id;
    logic [0:4]     addr;
    logic [0:31]    op1;
    logic [0:31]    op2;
    logic [0:31]    xer;
    mul_decode_t    ctrl;
  } op_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mul_issue_arbiter_if #(.NUM_REQ(NREQ), .RS_ID_WIDTH(IDW)) bus ();

`ifdef MUL_ARB_STATS_EN
  logic [0:31] stat_issued, stat_credit_stall, stat_slot_stall;
`endif

  mul_issue_arbiter #(
    .NUM_REQ(NREQ), .RS_ID_WIDTH(IDW), .MAX_INFLIGHT(MAXF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef MUL_ARB_STATS_EN
    ,
    .stat_issued(stat_issued),
    .stat_credit_stall(stat_credit_stall),
    .stat_slot_stall(stat_slot_stall)
`endif
  );

  int   n_cmp = 0;
  int   n_err = 0;
  op_t  sb[$];
  op_t  drv[NREQ];
  logic m_valid = 1'b0;
  logic [3:0] m_cnt = 4'd0;
  int   m_rr = 0;
  logic auto_done = 1'b0;
  logic man_done  = 1'b0;
  logic vary      = 1'b0;
  logic [3:0] done_pipe = 4'd0;
  int   seed = 0;
  int   loads = 0;
  int   pulses1 = 0;
  int   grant_log[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic gen_data(input int s);
    for (int i = 0; i < NREQ; i++) begin
      drv[i].rs_id = IDW'(s * 4 + i);
      drv[i].addr  = 5'(s + 7 * i);
      drv[i].op1   = 32'h1000_0000 + 32'(s * 16 + i);
      drv[i].op2   = 32'hA5A5_0000 ^ 32'(s * 3 + i * 1000);
      drv[i].xer   = (32'(s) << 8) | 32'(i);
      drv[i].ctrl  = mul_decode_t'(4'(s + i));
    end
  endtask

  task automatic apply_drv();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_rs_id[i]           = drv[i].rs_id;
      bus.req_result_reg_addr[i] = drv[i].addr;
      bus.req_op1[i]             = drv[i].op1;
      bus.req_op2[i]             = drv[i].op2;
      bus.req_xer[i]             = drv[i].xer;
      bus.req_control[i]         = drv[i].ctrl;
    end
  endtask

  // One clock: drive, check just before the edge, update model, step past the edge.
  task automatic cycle();
    logic [0:NREQ-1] exp_rdy;
    logic slot_free, credit_ok, exp_load, hs, acc;
    int   g, c, dg;
    op_t  e;
    if (vary) begin
      seed++;
      gen_data(seed);
      apply_drv();
    end
    bus.mul_done = auto_done ? done_pipe[3] : man_done;
    @(negedge clk);
    slot_free = !m_valid || bus.mul_ready;
    credit_ok = (m_cnt < 4'(MAXF)) || bus.mul_done;
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      c = (m_rr + k) % NREQ;
      if (g < 0 && bus.req_valid[c]) g = c;
    end
    exp_load = !rst && slot_free && credit_ok && (g >= 0);
    exp_rdy = '0;
    if (exp_load) exp_rdy[g] = 1'b1;
    chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
    chk("mul_valid", 64'(bus.mul_valid), 64'(m_valid));
    chk("inflight_cnt", 64'(bus.inflight_cnt), 64'(m_cnt));
    hs = bus.mul_valid && bus.mul_ready;
    if (hs) begin
      chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("mul_rs_id", 64'(bus.mul_rs_id), 64'(e.rs_id));
        chk("mul_addr", 64'(bus.mul_result_reg_addr), 64'(e.addr));
        chk("mul_op1", 64'(bus.mul_op1), 64'(e.op1));
        chk("mul_op2", 64'(bus.mul_op2), 64'(e.op2));
        chk("mul_xer", 64'(bus.mul_xer), 64'(e.xer));
        chk("mul_control", 64'(bus.mul_control), 64'(e.ctrl));
      end
    end
    acc = |(bus.req_valid & bus.req_ready);
    if (acc) begin
      loads++;
      dg = -1;
      for (int k = 0; k < NREQ; k++) if (bus.req_ready[k]) dg = k;
      grant_log.push_back(dg);
    end
    if (bus.req_ready[1] === 1'b1) pulses1++;
    if (exp_load) begin
      sb.push_back(drv[g]);
      m_valid = 1'b1;
      m_rr = (g + 1) % NREQ;
    end else if (bus.mul_ready) begin
      m_valid = 1'b0;
    end
    if (exp_load && !(bus.mul_done && m_cnt != 0)) m_cnt = m_cnt + 4'd1;
    else if (!exp_load && bus.mul_done && m_cnt != 0) m_cnt = m_cnt - 4'd1;
    done_pipe = {done_pipe[2:0], acc};
    @(posedge clk);
    #1;
    if (rst) begin
      m_valid = 1'b0;
      m_cnt = 4'd0;
      m_rr = 0;
      done_pipe = 4'd0;
      sb.delete();
    end
  endtask

  initial begin
    bus.req_valid = '0;
    bus.mul_ready = 1'b0;
    bus.mul_done  = 1'b0;
    gen_data(0);
    apply_drv();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Step 1: idle after reset
    chk("reset_mul_op1", 64'(bus.mul_op1), 64'd0);
    chk("reset_mul_rs_id", 64'(bus.mul_rs_id), 64'd0);
    repeat (10) cycle();

    // Step 2: all requesters, full rate, mul_done 4 cycles after each load
    vary = 1'b1;
    auto_done = 1'b1;
    bus.mul_ready = 1'b1;
    bus.req_valid = '1;
    grant_log.delete();
    repeat (5) cycle();
    for (int i = 0; i < 5; i++)
      chk($sformatf("rr_grant_%0d", i),
          64'(i < grant_log.size() ? grant_log[i] : -1), 64'(i % NREQ));
    loads = 0;
    repeat (12) cycle();
    chk("sustained_loads", 64'(loads), 64'd12);
    chk("cnt_saturated", 64'(bus.inflight_cnt), 64'(MAXF));
    bus.req_valid = '0;
    repeat (8) cycle();
    chk("drain_cnt", 64'(bus.inflight_cnt), 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    auto_done = 1'b0;
    vary = 1'b0;

    // Step 3: single requester, slot stalled for 3 cycles
    gen_data(100);
    drv[1].op1 = 32'd7;
    drv[1].op2 = 32'd6;
    apply_drv();
    bus.mul_ready = 1'b0;
    bus.req_valid = '0;
    bus.req_valid[1] = 1'b1;
    pulses1 = 0;
    cycle();
    bus.req_valid[1] = 1'b0;
    repeat (3) begin
      chk("stall_op1", 64'(bus.mul_op1), 64'd7);
      chk("stall_op2", 64'(bus.mul_op2), 64'd6);
      cycle();
    end
    bus.mul_ready = 1'b1;
    cycle();
    chk("req1_pulses", 64'(pulses1), 64'd1);
    chk("cnt_single", 64'(bus.inflight_cnt), 64'd1);
    man_done = 1'b1;
    cycle();
    man_done = 1'b0;
    chk("cnt_cleared", 64'(bus.inflight_cnt), 64'd0);

    // Step 4: no completions, credit runs out after MAX_INFLIGHT issues
    vary = 1'b1;
    bus.req_valid = '1;
    loads = 0;
    repeat (12) cycle();
    chk("issues_no_done", 64'(loads), 64'(MAXF));
    chk("req_ready_blocked", 64'(bus.req_ready), 64'd0);
    loads = 0;
    man_done = 1'b1;
    cycle();
    man_done = 1'b0;
    // Step 5a: load and mul_done together at the cap
    chk("cnt_load_and_done", 64'(bus.inflight_cnt), 64'(MAXF));
    repeat (6) cycle();
    chk("issues_after_pulse", 64'(loads), 64'd1);

    // Step 5b: drain, then mul_done at zero must not underflow
    bus.req_valid = '0;
    vary = 1'b0;
    man_done = 1'b1;
    repeat (4) cycle();
    chk("cnt_drained", 64'(bus.inflight_cnt), 64'd0);
    cycle();
    chk("cnt_no_underflow", 64'(bus.inflight_cnt), 64'd0);
    man_done = 1'b0;
    chk("sb_empty_5", 64'(sb.size()), 64'd0);

    // Step 6: reset with the slot full and three ops in flight
    vary = 1'b1;
    bus.req_valid = '0;
    bus.req_valid[1] = 1'b1;
    bus.req_valid[2] = 1'b1;
    bus.mul_ready = 1'b1;
    repeat (3) cycle();
    bus.mul_ready = 1'b0;
    bus.req_valid = '0;
    cycle();
    chk("pre_rst_valid", 64'(bus.mul_valid), 64'd1);
    chk("pre_rst_cnt", 64'(bus.inflight_cnt), 64'd3);
    rst = 1'b1;
    bus.req_valid = '1;
    cycle();
    rst = 1'b0;
    chk("post_rst_valid", 64'(bus.mul_valid), 64'd0);
    chk("post_rst_cnt", 64'(bus.inflight_cnt), 64'd0);
    chk("post_rst_op1", 64'(bus.mul_op1), 64'd0);
    bus.mul_ready = 1'b1;
    grant_log.delete();
    cycle();
    chk("grant_after_reset",
        64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'd0);
    bus.req_valid = '0;
    repeat (3) cycle();
    chk("sb_empty_end", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
